activity_stim_gen: RTL and testbench
====================================

# activity_stim_gen

Synthesizable, parametrised traffic and switching-activity generator for energy characterization of arithmetic datapaths such as adders. It emits packets of flits on a valid/ready stream and splits each 2N-bit flit word into two N-bit operands. The flit word is a Johnson-counter sequence that toggles a programmable number of bits per flit. Packet length, inter-packet gap, packet count and per-flit toggle step are run-time configurable, so link utilization and bit activity can be swept without editing the bench.

## Interface
- N, 25: operand width; the flit word W is 2N bits.
- LEN_W, 8: width of cfg_payload.
- GAP_W, 8: width of cfg_gap.
- PKT_W, 8: width of cfg_npkt and pkt_idx.
- STEP_W, 8: width of cfg_step.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  run request; sampled only in IDLE.
- cfg_payload  in  LEN_W  flits per packet; sampled at start.
- cfg_gap  in  GAP_W  idle cycles after each packet; sampled at start.
- cfg_npkt  in  PKT_W  packets per run; sampled at start.
- cfg_step  in  STEP_W  Johnson positions advanced per flit; sampled at start and reduced mod 4N.
- out_valid  out  1  flit present.
- out_ready  in  1  downstream accepts the flit.
- op_a  out  N  W[N-1:0].
- op_b  out  N  W[2N-1:N].
- last  out  1  current flit is the last of its packet; qualified by out_valid.
- pkt_idx  out  PKT_W  current packet number, 0-based.
- busy  out  1  high in SEND and GAP.
- done  out  1  one-cycle pulse at end of run.
- toggle_cnt  out  32  accumulated operand bit toggles; present only with ACT_CNT_EN.

## Operation
- **States:**
  - IDLE: start=1 goes to SEND if cfg_payload≠0 and cfg_npkt≠0, otherwise to DONE.
  - SEND: advances to GAP when the last flit is accepted and cfg_gap≠0.
  - GAP, and SEND with cfg_gap=0: go to the next packet's SEND if packets remain, otherwise to DONE.
  - DONE lasts one cycle, then IDLE.
- **Johnson position:**
  - p ranges over [0,4N). At every packet start p=0; the first flit uses p=step.
  - Each accepted flit sets p←(p+step) mod 4N.
- **Word W(p):**
  - For p≤2N, the top p bits are ones and the rest zeros.
  - For p>2N, the bottom 4N−p bits are ones and the rest zeros.
  - step=0 gives a constant all-zero word.
- **Operand hold:** op_a and op_b update only when a new flit is presented. They hold their last value through GAP, DONE and IDLE, which emulates a quiet link.
- **Flit transfer:** a flit transfers when out_valid and out_ready are both high. While out_ready=0, out_valid, op_a, op_b and last remain stable.
- **start while busy:** ignored.
- **Config changes mid-run:** ignored; the configuration sampled at start is used for the whole run.

## Timing
- **Reset:** rst_n=0 for one edge forces:
  - state IDLE;
  - out_valid, last, busy and done to 0;
  - op_a, op_b, pkt_idx and toggle_cnt to 0;
  - p to 0.
  
  Reset mid-run aborts immediately, and no done pulse is produced.
- **Start latency:** start is sampled at edge t. The first flit is valid at t+1 with p=step.
- **Flit rate:** one flit per cycle while out_ready=1.
- **Packet boundary:**
  - The last flit is accepted at cycle c.
  - GAP occupies c+1 … c+cfg_gap.
  - The next packet's first flit is valid at c+cfg_gap+1.
  - pkt_idx increments when the next packet's first flit is presented.
- **End of run:**
  - After the final packet's gap, done=1 for one cycle and busy=0.
  - With cfg_gap=0, done follows the last acceptance by one cycle.
  - The run length with out_ready held at 1 is cfg_npkt×(cfg_payload+cfg_gap) cycles, followed by done.
- **Wrap-around:** p wraps at 4N and is never forced to 0 within a packet.

## Configuration
- ACT_CNT_EN defined:
  - On every accepted flit, toggle_cnt += popcount(W_new XOR W_prev), where W_prev is the last accepted word (0 after reset).
  - toggle_cnt clears when start is accepted and saturates at 2^32−1.
- ACT_CNT_EN undefined: the toggle_cnt port and its logic are absent.

## Test plan
- **Default run:** N=25, payload=20, gap=7, npkt=10, step=7, out_ready=1, start at cycle 0.
  - Flit 1: op_b=25'h1FC0000, op_a=0.
  - Flit 8 (p=56): op_b=25'h007FFFF, op_a=25'h1FFFFFF.
  - Flit 15 (p=5): op_b=25'h1F00000, op_a=0.
  - done=1 at cycle 271.
- **Same run with ACT_CNT_EN:** toggle_cnt=1634 at done, from 200×7 minus 9×7 plus 9×33.
- **Backpressure:** out_ready=0 for 3 cycles while flit 5 is presented.
  - Flit 5's out_valid and operands are stable for those cycles.
  - No flit is skipped.
  - done is delayed by exactly 3 cycles.
- **Degenerate configurations:**
  - cfg_npkt=0 or cfg_payload=0: done at t+1, no out_valid.
  - cfg_gap=0: packets are back-to-back, and the next packet's flit 1 restarts at p=step.
- **Reset and restart:**
  - Assert rst_n=0 during packet 3's GAP: all outputs return to 0 the next cycle, with no done.
  - A new start then begins again from pkt_idx=0, p=step.
- **start while busy:** pulse start during SEND; it has no effect on state, pkt_idx or configuration.

Source files
------------

// File: rtl/activity_stim_gen.sv
// Johnson-counter flit and operand stimulus generator for datapath energy sweeps.
// Define ACT_CNT_EN to add the toggle_cnt operand-activity counter.
module activity_stim_gen #(
    parameter int N      = 25,
    parameter int LEN_W  = 8,
    parameter int GAP_W  = 8,
    parameter int PKT_W  = 8,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_payload,
    input  logic [GAP_W-1:0]  cfg_gap,
    input  logic [PKT_W-1:0]  cfg_npkt,
    input  logic [STEP_W-1:0] cfg_step,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      op_a,
    output logic [N-1:0]      op_b,
    output logic              last,
    output logic [PKT_W-1:0]  pkt_idx,
    output logic              busy,
    output logic              done
`ifdef ACT_CNT_EN
    ,
    output logic [31:0]       toggle_cnt
`endif
);

    localparam int W   = 2 * N;
    localparam int P_W = $clog2(4 * N);

    localparam logic [P_W-1:0] HALF = P_W'(W);
    localparam logic [P_W:0]   FULL = (P_W + 1)'(4 * N);
    localparam logic [W-1:0]   ONES = '1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] payload_q, payload_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [PKT_W-1:0] npkt_q, npkt_d;
    logic [P_W-1:0]   step_q, step_d;
    logic [P_W-1:0]   pos_q, pos_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;
    logic [PKT_W-1:0] pkt_q, pkt_d;
    logic [W-1:0]     word_q, word_d;

    logic [P_W-1:0]   step_red;
    logic [P_W:0]     pos_sum;
    logic [P_W-1:0]   pos_nxt;
    logic             more;

    // Top p ones up to half the ring, then ones drain out from the top.
    function automatic logic [W-1:0] word_of(input logic [P_W-1:0] p);
        if (p <= HALF) begin
            return ~(ONES >> p);
        end
        return ONES >> (p - HALF);
    endfunction

    assign step_red = P_W'(32'(cfg_step) % 32'(4 * N));

    always_comb begin
        pos_sum = {1'b0, pos_q} + {1'b0, step_q};
        if (pos_sum >= FULL) begin
            pos_nxt = P_W'(pos_sum - FULL);
        end else begin
            pos_nxt = pos_sum[P_W-1:0];
        end
    end

    assign more = ((PKT_W + 1)'(pkt_q) + (PKT_W + 1)'(1))
                < (PKT_W + 1)'(npkt_q);

    always_comb begin
        state_d   = state_q;
        payload_d = payload_q;
        gap_d     = gap_q;
        npkt_d    = npkt_q;
        step_d    = step_q;
        pos_d     = pos_q;
        rem_d     = rem_q;
        gcnt_d    = gcnt_q;
        pkt_d     = pkt_q;
        word_d    = word_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    payload_d = cfg_payload;
                    gap_d     = cfg_gap;
                    npkt_d    = cfg_npkt;
                    step_d    = step_red;
                    pkt_d     = '0;
                    if (cfg_payload != '0 && cfg_npkt != '0) begin
                        state_d = S_SEND;
                        pos_d   = step_red;
                        rem_d   = cfg_payload;
                        word_d  = word_of(step_red);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    if (rem_q != LEN_W'(1)) begin
                        rem_d  = rem_q - LEN_W'(1);
                        pos_d  = pos_nxt;
                        word_d = word_of(pos_nxt);
                    end else if (gap_q != '0) begin
                        state_d = S_GAP;
                        gcnt_d  = gap_q;
                    end else if (more) begin
                        pkt_d  = pkt_q + PKT_W'(1);
                        pos_d  = step_q;
                        rem_d  = payload_q;
                        word_d = word_of(step_q);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_GAP: begin
                if (gcnt_q != GAP_W'(1)) begin
                    gcnt_d = gcnt_q - GAP_W'(1);
                end else if (more) begin
                    state_d = S_SEND;
                    pkt_d   = pkt_q + PKT_W'(1);
                    pos_d   = step_q;
                    rem_d   = payload_q;
                    word_d  = word_of(step_q);
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            payload_q <= '0;
            gap_q     <= '0;
            npkt_q    <= '0;
            step_q    <= '0;
            pos_q     <= '0;
            rem_q     <= '0;
            gcnt_q    <= '0;
            pkt_q     <= '0;
            word_q    <= '0;
        end else begin
            state_q   <= state_d;
            payload_q <= payload_d;
            gap_q     <= gap_d;
            npkt_q    <= npkt_d;
            step_q    <= step_d;
            pos_q     <= pos_d;
            rem_q     <= rem_d;
            gcnt_q    <= gcnt_d;
            pkt_q     <= pkt_d;
            word_q    <= word_d;
        end
    end

    assign out_valid = (state_q == S_SEND);
    assign last      = out_valid && (rem_q == LEN_W'(1));
    assign busy      = (state_q == S_SEND) || (state_q == S_GAP);
    assign done      = (state_q == S_DONE);
    assign pkt_idx   = pkt_q;
    assign op_a      = word_q[N-1:0];
    assign op_b      = word_q[W-1:N];

`ifdef ACT_CNT_EN
    logic [W-1:0] wprev_q, wprev_d;
    logic [31:0]  tcnt_q, tcnt_d;
    logic [32:0]  tsum;
    logic         fire;

    function automatic logic [31:0] popcnt(input logic [W-1:0] v);
        logic [31:0] c;
        c = '0;
        for (int i = 0; i < W; i++) begin
            c = c + 32'(v[i]);
        end
        return c;
    endfunction

    assign fire = out_valid && out_ready;

    // Previous accepted word survives across runs; only reset clears it.
    always_comb begin
        wprev_d = wprev_q;
        tcnt_d  = tcnt_q;
        tsum    = {1'b0, tcnt_q} + {1'b0, popcnt(word_q ^ wprev_q)};
        if (state_q == S_IDLE && start) begin
            tcnt_d = '0;
        end else if (fire) begin
            wprev_d = word_q;
            tcnt_d  = tsum[32] ? 32'hFFFF_FFFF : tsum[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wprev_q <= '0;
            tcnt_q  <= '0;
        end else begin
            wprev_q <= wprev_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign toggle_cnt = tcnt_q;
`endif

endmodule

// File: tb/tb_activity_stim_gen.sv
// Randomized self-checking bench for activity_stim_gen against a
// flit-schedule reference model built from the packet/Johnson rules.
module tb_activity_stim_gen;

    localparam int N  = 25;
    localparam int W  = 2 * N;
    localparam int P4 = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   cfg_payload = '0;
    logic [7:0]   cfg_gap = '0;
    logic [7:0]   cfg_npkt = '0;
    logic [7:0]   cfg_step = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         last;
    logic [7:0]   pkt_idx;
    logic         busy;
    logic         done;
`ifdef ACT_CNT_EN
    logic [31:0]  toggle_cnt;
`endif

    always #5 clk = ~clk;

    activity_stim_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_payload(cfg_payload),
        .cfg_gap    (cfg_gap),
        .cfg_npkt   (cfg_npkt),
        .cfg_step   (cfg_step),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .last       (last),
        .pkt_idx    (pkt_idx),
        .busy       (busy),
        .done       (done)
`ifdef ACT_CNT_EN
        ,
        .toggle_cnt (toggle_cnt)
`endif
    );

    typedef struct {
        logic [W-1:0] w;
        bit           lst;
        int           pkt;
    } flit_t;

    int          n_chk = 0;
    int          n_fail = 0;
    flit_t       q[$];
    logic [W-1:0] wprev_m = '0;
    logic [31:0]  tog_m = '0;
    logic [W-1:0] seen [0:15];
    int           cyc;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Word straight from the ring rule, one bit at a time.
    function automatic logic [W-1:0] word_m(input int p);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            w[i] = (p <= W) ? (i >= W - p) : (i < P4 - p);
        end
        return w;
    endfunction

    task automatic rand_cfg();
        cfg_payload = 8'($urandom);
        cfg_gap     = 8'($urandom);
        cfg_npkt    = 8'($urandom);
        cfg_step    = 8'($urandom);
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_valid"}, 64'(out_valid), 64'(0));
        chk({pfx, "_last"},  64'(last), 64'(0));
        chk({pfx, "_busy"},  64'(busy), 64'(0));
        chk({pfx, "_done"},  64'(done), 64'(0));
        chk({pfx, "_op_a"},  64'(op_a), 64'(0));
        chk({pfx, "_op_b"},  64'(op_b), 64'(0));
        chk({pfx, "_pkt"},   64'(pkt_idx), 64'(0));
`ifdef ACT_CNT_EN
        chk({pfx, "_tog"},   64'(toggle_cnt), 64'(0));
`endif
    endtask

    // mode 0: ready=1, 1: random ready, 2: stall flit 5 for 3 cycles
    task automatic run(input int pay, input int gap, input int npkt,
                       input int step, input int mode,
                       input int abort_pkt, output int ncyc);
        int    sm;
        int    wait_cnt;
        int    k;
        int    stall;
        bit    abort;
        bit    fin;
        longint t;
        flit_t f;
        sm = step % P4;
        wait_cnt = 0;
        k = 0;
        stall = 3;
        abort = 0;
        fin = 0;
        q.delete();
        for (int pk = 0; pk < npkt; pk++) begin
            for (int i = 1; i <= pay; i++) begin
                q.push_back('{word_m((i * sm) % P4), i == pay, pk});
            end
        end
        cfg_payload = 8'(pay);
        cfg_gap     = 8'(gap);
        cfg_npkt    = 8'(npkt);
        cfg_step    = 8'(step);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tog_m = '0;
        rand_cfg();
        ncyc = 0;
        for (int c = 1; c <= 4000 && !fin; c++) begin
            ncyc = c;
            start = 1'b0;
            if (mode == 0) begin
                out_ready = 1'b1;
            end else if (mode == 1) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
                if (wait_cnt == 0 && k == 4 && stall > 0) begin
                    out_ready = 1'b0;
                    stall--;
                end
            end
            if (wait_cnt > 0) begin
                if (abort) begin
                    rst_n = 1'b0;
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                    wprev_m = '0;
                    tog_m = '0;
                    check_zero("abort");
                    repeat (3) begin
                        @(posedge clk); #1;
                        chk("abort_no_done", 64'(done), 64'(0));
                        chk("abort_idle", 64'(busy), 64'(0));
                    end
                    ncyc = -1;
                    return;
                end
                chk("gap_valid", 64'(out_valid), 64'(0));
                chk("gap_busy", 64'(busy), 64'(1));
                chk("gap_hold", 64'({op_b, op_a}), 64'(wprev_m));
                wait_cnt--;
            end else if (q.size() > 0) begin
                f = q[0];
                chk("valid", 64'(out_valid), 64'(1));
                chk("op_a", 64'(op_a), 64'(f.w[N-1:0]));
                chk("op_b", 64'(op_b), 64'(f.w[W-1:N]));
                chk("last", 64'(last), 64'(f.lst));
                chk("pkt_idx", 64'(pkt_idx), 64'(f.pkt));
                chk("busy", 64'(busy), 64'(1));
                if (out_ready) begin
                    void'(q.pop_front());
                    t = longint'(tog_m) + longint'($countones(f.w ^ wprev_m));
                    tog_m = (t > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(t);
                    wprev_m = f.w;
                    k++;
                    if (k < 16) seen[k] = {op_b, op_a};
                    if (f.lst) begin
                        wait_cnt = gap;
                        abort = (f.pkt == abort_pkt) && (gap > 0);
                    end
                end
            end else begin
                chk("done", 64'(done), 64'(1));
                chk("done_busy", 64'(busy), 64'(0));
                chk("done_valid", 64'(out_valid), 64'(0));
                chk("done_hold", 64'({op_b, op_a}), 64'(wprev_m));
`ifdef ACT_CNT_EN
                chk("toggle_cnt", 64'(toggle_cnt), 64'(tog_m));
`endif
                fin = 1;
            end
            if (!fin) begin
                if (mode == 1 ? ($urandom_range(0, 7) == 0) : (c == 3)) begin
                    start = 1'b1;
                    rand_cfg();
                end
                @(posedge clk); #1;
            end
        end
        chk("run_finished", 64'(fin), 64'(1));
        start = 1'b0;
        @(posedge clk); #1;
        chk("done_pulse", 64'(done), 64'(0));
        chk("after_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(20, 7, 10, 7, 0, -1, cyc);
        chk("default_done_cycle", 64'(cyc), 64'(271));
        chk("flit1_b", 64'(seen[1][W-1:N]), 64'h1FC0000);
        chk("flit1_a", 64'(seen[1][N-1:0]), 64'h0);
        chk("flit8_b", 64'(seen[8][W-1:N]), 64'h007FFFF);
        chk("flit8_a", 64'(seen[8][N-1:0]), 64'h1FFFFFF);
        chk("flit15_b", 64'(seen[15][W-1:N]), 64'h1F00000);
        chk("flit15_a", 64'(seen[15][N-1:0]), 64'h0);
`ifdef ACT_CNT_EN
        chk("toggle_default", 64'(toggle_cnt), 64'(1634));
`endif

        run(20, 7, 10, 7, 2, -1, cyc);
        chk("bp_done_cycle", 64'(cyc), 64'(274));

        run(5, 3, 0, 9, 0, -1, cyc);
        chk("npkt0_done", 64'(cyc), 64'(1));
        run(0, 3, 4, 9, 0, -1, cyc);
        chk("pay0_done", 64'(cyc), 64'(1));
        run(4, 0, 3, 30, 0, -1, cyc);
        chk("gap0_done", 64'(cyc), 64'(13));

        run(6, 2, 5, 200, 0, 2, cyc);
        chk("abort_ret", 64'(cyc), 64'(-1));
        run(6, 2, 5, 200, 0, -1, cyc);
        chk("restart_done", 64'(cyc), 64'(41));

        for (int r = 0; r < 14; r++) begin
            run($urandom_range(0, 6), $urandom_range(0, 4),
                $urandom_range(0, 4), $urandom_range(0, 255), 1, -1, cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
